// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, access-size encodings, alignment rule.
// Pure declarations, so there is no latency and no backpressure.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // Size 2'b11 has no legal encoding, so it is always reported as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return lsb[0];
      SIZE_W:  return (lsb != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane extraction/extension for loads and lane merge for sub-word stores.
// Purely combinational (zero latency), so it has no backpressure.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] mem_word,
  input  logic [1:0]            addr_lsb,
  input  logic [1:0]            size,
  input  logic                  is_unsigned,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] store_word
);

  logic [4:0]            shamt;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] base_mask;
  logic [DATA_WIDTH-1:0] lane_mask;

  assign shamt   = {addr_lsb, 3'b000};
  assign shifted = mem_word >> shamt;

  always_comb begin
    load_data = mem_word;
    base_mask = '1;
    case (size)
      SIZE_B: begin
        load_data = {{(DATA_WIDTH-8){~is_unsigned & shifted[7]}}, shifted[7:0]};
        base_mask = '0;
        base_mask[7:0] = '1;
      end
      SIZE_H: begin
        load_data = {{(DATA_WIDTH-16){~is_unsigned & shifted[15]}}, shifted[15:0]};
        base_mask = '0;
        base_mask[15:0] = '1;
      end
      default: begin
        load_data = mem_word;
        base_mask = '1;
      end
    endcase
  end

  // Only the addressed lanes take store data; the rest keep the word read back from memory.
  assign lane_mask  = base_mask << shamt;
  assign store_word = (mem_word & ~lane_mask) | ((wdata << shamt) & lane_mask);

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: misaligned 1 cycle, load and word store 2, sub-word store 3 (read-modify-write).
// Latency counts cycles from acceptance to the response pulse; Req_Ready_o is high only when idle, so requests stall until the unit is free.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Req_Valid_i,
  output logic                  Req_Ready_o,
  input  logic                  Req_Write_i,
  input  logic [1:0]            Req_Size_i,
  input  logic                  Req_Unsigned_i,
  input  logic [ADDR_WIDTH-1:0] Req_Address_i,
  input  logic [DATA_WIDTH-1:0] Req_Wdata_i,
  output logic                  Resp_Valid_o,
  output logic [DATA_WIDTH-1:0] Resp_Rdata_o,
  output logic                  Resp_Misaligned_o,
  output logic                  Mem_Read_o,
  output logic                  Mem_Write_o,
  output logic [ADDR_WIDTH-1:0] Mem_Address_o,
  output logic [DATA_WIDTH-1:0] Mem_Write_Data_o,
  input  logic [DATA_WIDTH-1:0] Mem_Read_Data_i
);

  lsu_state_t            state, state_nxt;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  req_err;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] store_word;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] word_addr;

  assign accept    = (state == IDLE) && Req_Valid_i;
  assign word_addr = {req_addr[ADDR_WIDTH-1:2], 2'b00};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_write    <= 1'b0;
      req_size     <= 2'b00;
      req_unsigned <= 1'b0;
      req_addr     <= '0;
      req_wdata    <= '0;
      req_err      <= 1'b0;
      rd_word      <= '0;
    end else begin
      if (accept) begin
        req_write    <= Req_Write_i;
        req_size     <= Req_Size_i;
        req_unsigned <= Req_Unsigned_i;
        req_addr     <= Req_Address_i;
        req_wdata    <= Req_Wdata_i;
        req_err      <= is_misaligned(Req_Size_i, Req_Address_i[1:0]);
      end
      if (state == READ) begin
        rd_word <= Mem_Read_Data_i;
      end
    end
  end

  lsu_lane_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_lane_align (
    .mem_word    (rd_word),
    .addr_lsb    (req_addr[1:0]),
    .size        (req_size),
    .is_unsigned (req_unsigned),
    .wdata       (req_wdata),
    .load_data   (load_data),
    .store_word  (store_word)
  );

  // Memory strobes decode straight from state, so an async reset drops them in the same cycle.
  always_comb begin
    state_nxt         = state;
    Req_Ready_o       = 1'b0;
    Resp_Valid_o      = 1'b0;
    Resp_Rdata_o      = '0;
    Resp_Misaligned_o = 1'b0;
    Mem_Read_o        = 1'b0;
    Mem_Write_o       = 1'b0;
    Mem_Address_o     = '0;
    Mem_Write_Data_o  = '0;
    case (state)
      IDLE: begin
        Req_Ready_o = 1'b1;
        if (Req_Valid_i) begin
          if (is_misaligned(Req_Size_i, Req_Address_i[1:0])) begin
            state_nxt = RESP;
          end else if (!Req_Write_i || (Req_Size_i != SIZE_W)) begin
            state_nxt = READ;
          end else begin
            state_nxt = WRITE;
          end
        end
      end
      READ: begin
        Mem_Read_o    = 1'b1;
        Mem_Address_o = word_addr;
        state_nxt     = req_write ? WRITE : RESP;
      end
      WRITE: begin
        Mem_Write_o      = 1'b1;
        Mem_Address_o    = word_addr;
        Mem_Write_Data_o = (req_size == SIZE_W) ? req_wdata : store_word;
        state_nxt        = RESP;
      end
      RESP: begin
        Resp_Valid_o      = 1'b1;
        Resp_Misaligned_o = req_err;
        Resp_Rdata_o      = (req_err || req_write) ? '0 : load_data;
        state_nxt         = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized requests against a byte-level memory model.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_mis;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_val;

  int vectors;
  int miscompares;

  int          obs_lat;
  logic [31:0] obs_rdata;
  logic        obs_mis;
  logic [7:0]  obs_rd_mask;
  logic [7:0]  obs_wr_mask;
  logic [31:0] obs_wr_addr;
  logic [31:0] obs_wr_data;
  logic        obs_both;
  logic        obs_leak;
  logic        obs_ready_busy;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk               (clk),
    .reset             (rst_n),
    .Req_Valid_i       (req_valid),
    .Req_Ready_o       (req_ready),
    .Req_Write_i       (req_write),
    .Req_Size_i        (req_size),
    .Req_Unsigned_i    (req_unsigned),
    .Req_Address_i     (req_addr),
    .Req_Wdata_i       (req_wdata),
    .Resp_Valid_o      (resp_valid),
    .Resp_Rdata_o      (resp_rdata),
    .Resp_Misaligned_o (resp_mis),
    .Mem_Read_o        (mem_rd),
    .Mem_Write_o       (mem_wr),
    .Mem_Address_o     (mem_addr),
    .Mem_Write_Data_o  (mem_wdata),
    .Mem_Read_Data_i   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr[7:2]] <= mem_wdata;
    else if (pl_en) mem[pl_idx] <= pl_val;
  end

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    pl_en  = 1'b1;
    pl_idx = idx[5:0];
    pl_val = val;
    @(posedge clk);
    #1 pl_en = 1'b0;
    ref_mem[idx] = val;
  endtask

  // Issue one request and record what the unit does over the following cycles.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic un,
                         input logic [31:0] a, input logic [31:0] wd);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = un;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    obs_lat = 0; obs_rdata = 'x; obs_mis = 1'bx; obs_rd_mask = '0; obs_wr_mask = '0;
    obs_wr_addr = '0; obs_wr_data = '0; obs_both = 1'b0; obs_leak = 1'b0; obs_ready_busy = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (mem_rd) obs_rd_mask[k] = 1'b1;
      if (mem_wr) begin
        obs_wr_mask[k] = 1'b1;
        obs_wr_addr = mem_addr;
        obs_wr_data = mem_wdata;
      end
      if (mem_rd && mem_wr) obs_both = 1'b1;
      if (!mem_wr && mem_wdata != 32'h0) obs_leak = 1'b1;
      if (req_ready) obs_ready_busy = 1'b1;
      if (resp_valid) begin
        obs_lat = k;
        obs_rdata = resp_rdata;
        obs_mis = resp_mis;
        break;
      end
    end
  endtask

  task automatic test_reset;
    vectors++;
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    vectors++;
    if ({resp_valid, resp_mis, mem_rd, mem_wr} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_strobes: got %b want 0000", {resp_valid, resp_mis, mem_rd, mem_wr});
    end
    vectors++;
    if ({resp_rdata, mem_addr, mem_wdata} !== 96'h0) begin
      miscompares++; $display("FAIL reset_buses: got %h %h %h want 0", resp_rdata, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_byte_load;
    run_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    vectors++;
    if (obs_lat !== 2) begin miscompares++; $display("FAIL lb_latency: got %0d want 2", obs_lat); end
    vectors++;
    if (obs_rdata !== 32'hFFFFFF88) begin miscompares++; $display("FAIL lb_rdata: got %h want ffffff88", obs_rdata); end
    vectors++;
    if (obs_rd_mask !== 8'b0000_0010 || obs_wr_mask !== 8'h0) begin
      miscompares++; $display("FAIL lb_mem_strobes: got rd %b wr %b want rd 00000010 wr 0", obs_rd_mask, obs_wr_mask);
    end
  endtask

  task automatic test_half_load_unsigned;
    run_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    vectors++;
    if (obs_rdata !== 32'h00008899) begin miscompares++; $display("FAIL lhu_rdata: got %h want 00008899", obs_rdata); end
    vectors++;
    if (obs_mis !== 1'b0 || obs_lat !== 2) begin
      miscompares++; $display("FAIL lhu_resp: got mis %b lat %0d want mis 0 lat 2", obs_mis, obs_lat);
    end
  endtask

  task automatic test_misaligned;
    run_req(1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
    vectors++;
    if (obs_lat !== 1 || obs_mis !== 1'b1) begin
      miscompares++; $display("FAIL mis_resp: got lat %0d mis %b want lat 1 mis 1", obs_lat, obs_mis);
    end
    vectors++;
    if (obs_rdata !== 32'h0) begin miscompares++; $display("FAIL mis_rdata: got %h want 0", obs_rdata); end
    vectors++;
    if (obs_rd_mask !== 8'h0 || obs_wr_mask !== 8'h0) begin
      miscompares++; $display("FAIL mis_no_access: got rd %b wr %b want 0", obs_rd_mask, obs_wr_mask);
    end
  endtask

  task automatic test_reset_mid_write;
    int resp_cnt;
    resp_cnt = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h00001234;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (mem_wr !== 1'b1) begin miscompares++; $display("FAIL rst_mid_in_write: got %b want 1", mem_wr); end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (mem_wr !== 1'b0 || mem_wdata !== 32'h0) begin
      miscompares++; $display("FAIL rst_mid_write_drop: got wr %b data %h want 0", mem_wr, mem_wdata);
    end
    vectors++;
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_mid_ready: got %b want 1", req_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (resp_valid) resp_cnt++;
    end
    vectors++;
    if (resp_cnt !== 0) begin miscompares++; $display("FAIL rst_mid_no_resp: got %0d pulses want 0", resp_cnt); end
    vectors++;
    if (mem[4] !== 32'h8899AABB) begin miscompares++; $display("FAIL rst_mid_mem: got %h want 8899aabb", mem[4]); end
  endtask

  task automatic test_byte_store;
    run_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000CC);
    vectors++;
    if (obs_rd_mask !== 8'b0000_0010) begin miscompares++; $display("FAIL sb_read_cycle: got %b want 00000010", obs_rd_mask); end
    vectors++;
    if (obs_wr_mask !== 8'b0000_0100) begin miscompares++; $display("FAIL sb_write_cycle: got %b want 00000100", obs_wr_mask); end
    vectors++;
    if (obs_wr_addr !== 32'h10 || obs_wr_data !== 32'h8899CCBB) begin
      miscompares++; $display("FAIL sb_write_word: got %h@%h want 8899ccbb@00000010", obs_wr_data, obs_wr_addr);
    end
    vectors++;
    if (obs_lat !== 3 || obs_rdata !== 32'h0) begin
      miscompares++; $display("FAIL sb_resp: got lat %0d rdata %h want lat 3 rdata 0", obs_lat, obs_rdata);
    end
    ref_mem[4] = 32'h8899CCBB;
  endtask

  task automatic test_back_to_back;
    int          wr_cnt;
    int          wr_k [2];
    logic [31:0] wr_a [2];
    logic [31:0] wr_d [2];
    wr_cnt = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'hA5A5_0001;
    @(posedge clk);
    #1 req_addr = 32'h24; req_wdata = 32'h5A5A_0002;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_wr) begin
        if (wr_cnt < 2) begin
          wr_k[wr_cnt] = k; wr_a[wr_cnt] = mem_addr; wr_d[wr_cnt] = mem_wdata;
        end
        wr_cnt++;
      end
      if (k == 5) req_valid = 1'b0;
    end
    vectors++;
    if (wr_cnt !== 2) begin miscompares++; $display("FAIL b2b_write_count: got %0d want 2", wr_cnt); end
    else begin
      vectors++;
      if (wr_k[0] !== 1 || wr_k[1] !== 4) begin
        miscompares++; $display("FAIL b2b_write_cycles: got %0d,%0d want 1,4", wr_k[0], wr_k[1]);
      end
      vectors++;
      if (wr_a[0] !== 32'h20 || wr_d[0] !== 32'hA5A50001 || wr_a[1] !== 32'h24 || wr_d[1] !== 32'h5A5A0002) begin
        miscompares++; $display("FAIL b2b_write_data: got %h@%h %h@%h want a5a50001@20 5a5a0002@24",
                                wr_d[0], wr_a[0], wr_d[1], wr_a[1]);
      end
    end
    ref_mem[8] = 32'hA5A50001;
    ref_mem[9] = 32'h5A5A0002;
  endtask

  task automatic test_random;
    logic        w, un, err, sub_store;
    logic [1:0]  sz;
    logic [31:0] a, wd, word, exp_rdata, exp_word;
    logic [7:0]  exp_rd_mask, exp_wr_mask;
    int          exp_lat, nb, idx, lane;
    for (int n = 0; n < 200; n++) begin
      w = 1'($urandom); un = 1'($urandom);
      sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      wd = $urandom;
      idx = int'(a[7:2]);
      word = ref_mem[idx];
      err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
      nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      sub_store = w && (sz != 2'b10);
      exp_rdata = 32'h0;
      exp_word = word;
      if (!err && !w) begin
        exp_rdata = word >> (8 * a[1:0]);
        if (nb == 1) begin
          exp_rdata = exp_rdata & 32'hFF;
          if (!un && exp_rdata >= 32'h80) exp_rdata = exp_rdata | 32'hFFFFFF00;
        end else if (nb == 2) begin
          exp_rdata = exp_rdata & 32'hFFFF;
          if (!un && exp_rdata >= 32'h8000) exp_rdata = exp_rdata | 32'hFFFF0000;
        end
      end
      if (!err && w) begin
        for (int b = 0; b < nb; b++) begin
          lane = int'(a[1:0]) + b;
          exp_word[8*lane +: 8] = wd[8*b +: 8];
        end
      end
      exp_lat = err ? 1 : sub_store ? 3 : 2;
      exp_rd_mask = (!err && (!w || sub_store)) ? 8'b0000_0010 : 8'h0;
      exp_wr_mask = (err || !w) ? 8'h0 : sub_store ? 8'b0000_0100 : 8'b0000_0010;
      run_req(w, sz, un, a, wd);
      if (!err && w) ref_mem[idx] = exp_word;
      vectors++;
      if (obs_lat !== exp_lat) begin miscompares++; $display("FAIL rnd%0d_latency: got %0d want %0d", n, obs_lat, exp_lat); end
      vectors++;
      if (obs_mis !== err || obs_rdata !== exp_rdata) begin
        miscompares++; $display("FAIL rnd%0d_resp: got mis %b rdata %h want mis %b rdata %h", n, obs_mis, obs_rdata, err, exp_rdata);
      end
      vectors++;
      if (obs_rd_mask !== exp_rd_mask || obs_wr_mask !== exp_wr_mask) begin
        miscompares++; $display("FAIL rnd%0d_strobes: got rd %b wr %b want rd %b wr %b", n, obs_rd_mask, obs_wr_mask, exp_rd_mask, exp_wr_mask);
      end
      if (!err && w) begin
        vectors++;
        if (obs_wr_addr !== {a[31:2], 2'b00} || obs_wr_data !== exp_word) begin
          miscompares++; $display("FAIL rnd%0d_write: got %h@%h want %h@%h", n, obs_wr_data, obs_wr_addr, exp_word, {a[31:2], 2'b00});
        end
      end
      vectors++;
      if (obs_both || obs_leak || obs_ready_busy) begin
        miscompares++; $display("FAIL rnd%0d_protocol: got both %b leak %b ready_busy %b want 0 0 0", n, obs_both, obs_leak, obs_ready_busy);
      end
      vectors++;
      if (mem[idx] !== ref_mem[idx]) begin miscompares++; $display("FAIL rnd%0d_mem: got %h want %h", n, mem[idx], ref_mem[idx]); end
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; pl_en = 1'b0; pl_idx = '0; pl_val = '0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 64; i++) preload(i, $urandom);
    preload(4, 32'h8899AABB);
    test_reset;
    @(negedge clk);
    rst_n = 1'b1;
    test_byte_load;
    test_half_load_unsigned;
    test_misaligned;
    test_reset_mid_write;
    test_byte_store;
    test_back_to_back;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 SHALL have one clock and one asynchronous active-low reset: `clk  input  1  clock (posedge)`.
REQ-004 `reset  input  1  asynchronous, active-low reset`.
REQ-005 `Req_Valid_i  input  1  core request strobe`.
REQ-006 `Req_Ready_o  output  1  unit idle, request accepted this cycle if Req_Valid_i`.
REQ-007 `Req_Write_i  input  1  1=store, 0=load`.
REQ-008 `Req_Size_i  input  2  00 byte, 01 half, 10 word, 11 illegal`.
REQ-009 `Req_Unsigned_i  input  1  zero-extend loads`.
REQ-010 `Req_Address_i  input  ADDR_WIDTH  byte address`.
REQ-011 `Req_Wdata_i  input  DATA_WIDTH  store data, LSB-aligned`.
REQ-012 `Resp_Valid_o  output  1  one-cycle completion pulse`.
REQ-013 `Resp_Rdata_o  output  DATA_WIDTH  extended load data, 0 for stores/errors`.
REQ-014 `Resp_Misaligned_o  output  1  error flag, valid with Resp_Valid_o`.
REQ-015 `Mem_Read_o  output  1  data-memory read enable`.
REQ-016 `Mem_Write_o  output  1  data-memory write enable`.
REQ-017 `Mem_Address_o  output  ADDR_WIDTH  word-aligned address, bits[1:0]=0`.
REQ-018 `Mem_Write_Data_o  output  DATA_WIDTH  full word to write`.
REQ-019 `Mem_Read_Data_i  input  DATA_WIDTH  combinational read data, same cycle as address`.

Function
REQ-020 SHALL implement FSM states IDLE, READ, WRITE, RESP; Req_Ready_o=1 only in IDLE.
REQ-021 IDLE + Req_Valid_i: SHALL register the request. Misaligned cases (half with addr[0]=1; word with addr[1:0]≠0; size 11) go to RESP with error. Loads and sub-word stores go to READ. Word stores go to WRITE.
REQ-022 READ: SHALL drive Mem_Read_o=1 and register Mem_Read_Data_i at the cycle end. Loads then go to RESP; sub-word stores go to WRITE.
REQ-023 WRITE: SHALL drive Mem_Write_o=1 for exactly one cycle, then go to RESP. Sub-word stores SHALL replace only the addressed lanes of the captured word (read-modify-write); word stores write Req_Wdata_i unchanged.
REQ-024 RESP: SHALL pulse Resp_Valid_o for one cycle, then return to IDLE.
REQ-025 Byte ordering SHALL be little-endian: byte lane = addr[1:0], half lane = addr[1].
REQ-026 Load data SHALL be sign-extended from bit 7/15, or zero-extended when Req_Unsigned_i=1.
REQ-027 Latency from acceptance cycle T: misaligned Resp at T+1; load and word store at T+2; sub-word store at T+3.
REQ-028 Req_Valid_i SHALL be ignored outside IDLE; request inputs SHALL not need to stay stable after acceptance.
REQ-029 Mem_Read_o and Mem_Write_o SHALL never be 1 together; both SHALL be 0 in IDLE and RESP.
REQ-030 Mem_Write_Data_o SHALL be 0 outside WRITE.
REQ-031 A misaligned request SHALL cause no memory access.

Reset
REQ-032 reset low SHALL asynchronously force IDLE, Req_Ready_o=1, all other outputs 0, and clear all captured registers.
REQ-033 Reset mid-operation SHALL abort the operation, with Mem_Write_o dropping immediately and no partial write. No Resp_Valid_o pulse SHALL follow.

Structure
REQ-034 Package lsu_pkg SHALL hold the state enum and the size-encoding constants (SIZE_B, SIZE_H, SIZE_W).
REQ-035 Lane extraction/extension and store merging SHALL be in one combinational sub-module, lsu_lane_align.

Verification (memory word 0x10 preloaded with 0x8899AABB)
REQ-036 Signed byte load, addr 0x13 → Resp at T+2 with Rdata 0xFFFFFF88; Mem_Read_o high only at T+1.
REQ-037 Unsigned half load, addr 0x12 → Rdata 0x00008899, Misaligned=0.
REQ-038 Byte store, addr 0x11, Wdata 0x000000CC → READ at T+1; single Mem_Write_o at T+2 with 0x8899CCBB at address 0x10; Resp at T+3.
REQ-039 Word load, addr 0x12 → Resp at T+1 with Misaligned=1 and Rdata 0; no Mem_Read_o or Mem_Write_o.
REQ-040 Half store, addr 0x10, with reset asserted during WRITE → Mem_Write_o low immediately; memory still 0x8899AABB; no Resp; Req_Ready_o=1.
REQ-041 Req_Valid_i held high with two word stores → second accepted only in the IDLE cycle after the first RESP; exactly two write pulses.
